// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DATA_W = 32;
    localparam logic [DATA_W-1:0] DIV0_LO = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_e;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Operand/accumulator registers and one RADIX_BITS-wide shift-add or restoring-divide step.
// The multiply datapath exists only when MULDIV_MULT_EN is defined.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned RADIX_BITS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                step_i,
`ifdef MULDIV_MULT_EN
    input  logic                is_div_i,
`endif
    input  logic [DATA_W-1:0]   opa_i,
    input  logic [DATA_W-1:0]   opb_i,
    output logic [2*DATA_W-1:0] acc_o
);

    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W:0]     rem33;
    logic [DATA_W:0]     trial;
`ifdef MULDIV_MULT_EN
    logic [DATA_W:0]     sum;
`endif

    always_comb begin
        acc_d = acc_q;
        a_d   = a_q;
        b_d   = b_q;
        rem33 = '0;
        trial = '0;
`ifdef MULDIV_MULT_EN
        sum   = '0;
`endif
        if (load_i) begin
            a_d   = opa_i;
            b_d   = opb_i;
            acc_d = '0;
        end else if (step_i) begin
            for (int unsigned i = 0; i < RADIX_BITS; i++) begin
`ifdef MULDIV_MULT_EN
                if (!is_div_i) begin
                    // multiplier consumed from b LSB; carry lands in acc MSB on the right shift
                    sum   = {1'b0, acc_d[2*DATA_W-1:DATA_W]} + (b_d[0] ? {1'b0, a_q} : '0);
                    acc_d = {sum, acc_d[DATA_W-1:1]};
                    b_d   = {1'b0, b_d[DATA_W-1:1]};
                end else
`endif
                begin
                    // acc = {remainder, quotient}; dividend bits shift in from b MSB
                    rem33 = {acc_d[2*DATA_W-1:DATA_W], b_d[DATA_W-1]};
                    trial = rem33 - {1'b0, a_q};
                    if (!trial[DATA_W]) begin
                        acc_d = {trial[DATA_W-1:0], acc_d[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_d = {rem33[DATA_W-1:0], acc_d[DATA_W-2:0], 1'b0};
                    end
                    b_d = {b_d[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: FSM, sign correction, HI/LO and MTHI/MTLO writes.
// MULDIV_MULT_EN enables MULT/MULTU; otherwise multiply starts are ignored.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned RADIX_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              mthi_en,
    input  logic              mtlo_en,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned N    = DATA_W / RADIX_BITS;
    localparam logic [4:0]  LAST = 5'(N - 1);

    state_e              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                sa_q, sa_d, sb_q, sb_d, div0_q, div0_d;
`ifdef MULDIV_MULT_EN
    logic                is_div_q, is_div_d;
`endif
    logic                accept, op_ok, op_signed, launch;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   quot_fix, rem_fix;

    assign accept    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
`ifdef MULDIV_MULT_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = (op == OP_DIVU) || (op == OP_DIV);
`endif
    assign launch = accept && start && op_ok;

    muldiv_iter #(.RADIX_BITS(RADIX_BITS)) u_iter (
        .clk      (clk),
        .rst_n    (reset),
        .load_i   (launch),
        .step_i   (state_q == ST_RUN),
`ifdef MULDIV_MULT_EN
        .is_div_i (is_div_q),
`endif
        .opa_i    (mag(rt_val, op_signed && rt_val[DATA_W-1])),
        .opb_i    (mag(rs_val, op_signed && rs_val[DATA_W-1])),
        .acc_o    (acc)
    );

    // remainder takes the dividend sign, so a zero divisor yields the raw rs in HI
    assign quot_fix = div0_q ? DIV0_LO :
                      ((sa_q ^ sb_q) ? (~acc[DATA_W-1:0] + 1'b1) : acc[DATA_W-1:0]);
    assign rem_fix  = sa_q ? (~acc[2*DATA_W-1:DATA_W] + 1'b1) : acc[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        div0_d   = div0_q;
`ifdef MULDIV_MULT_EN
        is_div_d = is_div_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    sa_d     = op_signed && rs_val[DATA_W-1];
                    sb_d     = op_signed && rt_val[DATA_W-1];
                    div0_d   = (rt_val == '0);
`ifdef MULDIV_MULT_EN
                    is_div_d = op[1];
`endif
                end else begin
                    state_d = ST_IDLE;
                    if (mthi_en) hi_d = wdata;
                    if (mtlo_en) lo_d = wdata;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_DONE;
                hi_d    = rem_fix;
                lo_d    = quot_fix;
`ifdef MULDIV_MULT_EN
                if (!is_div_q) {hi_d, lo_d} = (sa_q ^ sb_q) ? (~acc + 64'd1) : acc;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            div0_q   <= 1'b0;
`ifdef MULDIV_MULT_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            div0_q   <= div0_d;
`ifdef MULDIV_MULT_EN
            is_div_q <= is_div_d;
`endif
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO queued at issue, checked on each done pulse.
// Multiply cases depend on MULDIV_MULT_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0, rt_val = '0, wdata = '0;
    logic        mthi_en = 1'b0, mtlo_en = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.RADIX_BITS(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .mthi_en (mthi_en),
        .mtlo_en (mtlo_en),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    end

    // result monitor
    always @(negedge clk) begin
        exp_t e;
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
            end else begin
                e = exp_q.pop_front();
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
        exp_q.push_back('{hi: eh, lo: el});
        busy_cnt = 0;
        issue(o, a, b);
        wait_done();
        check("busy_cycles", 32'(busy_cnt), 32'd33);
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        mthi_en = 1'b1; wdata = 32'hAAAA0000;
        @(posedge clk); #1;
        mthi_en = 1'b0;
        check("mthi_hi", hi, 32'hAAAA0000);
        check("mthi_lo", lo, 32'h0);

        mthi_en = 1'b1; mtlo_en = 1'b1; wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        mthi_en = 1'b0; mtlo_en = 1'b0;
        check("mtboth_hi", hi, 32'h0BADF00D);
        check("mtboth_lo", lo, 32'h0BADF00D);

        // start and MTHI on the same edge: MT write dropped
        exp_q.push_back('{hi: 32'd1, lo: 32'd4});
        busy_cnt = 0;
        mthi_en = 1'b1; wdata = 32'hCAFEBABE;
        issue(OP_DIVU, 32'd9, 32'd2);
        mthi_en = 1'b0;
        check("start_beats_mt", hi, 32'h0BADF00D);
        wait_done();
        check("busy_cycles", 32'(busy_cnt), 32'd33);
        @(posedge clk); #1;

        // second start and MTLO while busy are ignored
        exp_q.push_back('{hi: 32'd2, lo: 32'd14});
        busy_cnt = 0;
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        op = OP_DIVU; rs_val = 32'd50; rt_val = 32'd5; start = 1'b1;
        mtlo_en = 1'b1; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0; mtlo_en = 1'b0;
        check("busy_mid_run", {31'b0, busy}, 32'h1);
        check("lo_held_in_run", lo, 32'd4);
        wait_done();
        check("busy_cycles", 32'(busy_cnt), 32'd33);
        @(posedge clk); #1;

        run(OP_DIV,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2);
        run(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run(OP_DIVU, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF);
        run(OP_DIV,  32'hFFFFFF00, 32'h0,        32'hFFFFFF00, 32'hFFFFFFFF);

`ifdef MULDIV_MULT_EN
        run(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run(OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE);
        run(OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run(OP_MULTU, 32'd3,        32'd5,        32'h00000000, 32'h0000000F);
`else
        busy_cnt = 0;
        d0 = done_cnt;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (40) @(negedge clk);
        check("mult_off_busy", 32'(busy_cnt), 32'd0);
        check("mult_off_done", 32'(done_cnt), 32'(d0));
        check("mult_off_hi", hi, 32'hFFFFFF00);
        check("mult_off_lo", lo, 32'hFFFFFFFF);
        @(posedge clk); #1;
`endif

        // start during the done cycle is accepted
        exp_q.push_back('{hi: 32'd2, lo: 32'd14});
        busy_cnt = 0;
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done();
        check("busy_cycles", 32'(busy_cnt), 32'd33);
        exp_q.push_back('{hi: 32'd0, lo: 32'd100});
        busy_cnt = 0;
        op = OP_DIVU; rs_val = 32'd1000; rt_val = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", {31'b0, busy}, 32'h1);
        check("b2b_done", {31'b0, done}, 32'h0);
        wait_done();
        check("busy_cycles", 32'(busy_cnt), 32'd33);
        @(posedge clk); #1;

        // reset at RUN counter 10 aborts the operation
        d0 = done_cnt;
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(d0));

        check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
